// File: rtl/bp_pkg.sv
// Shared branch predictor types: 2-bit counter encodings and the table entry record.
package bp_pkg;

   localparam logic [1:0] SNT = 2'b00;
   localparam logic [1:0] WNT = 2'b01;
   localparam logic [1:0] WT  = 2'b10;
   localparam logic [1:0] ST  = 2'b11;

   // Fields are sized for the widest supported XLEN; the predictor uses the low bits.
   localparam int BP_MAX_XLEN = 64;

   typedef struct packed {
      logic                   valid;
      logic [1:0]             ctr;
      logic [BP_MAX_XLEN-1:0] tag;
      logic [BP_MAX_XLEN-1:0] target;
   } bp_entry_t;

endpackage

// File: rtl/sat_counter2.sv
// Next-state function of a 2-bit saturating taken/not-taken counter.
module sat_counter2
   import bp_pkg::*;
(
   input  logic [1:0] ctr_i,
   input  logic       taken_i,
   output logic [1:0] ctr_o
);

   always_comb begin
      ctr_o = ctr_i;
      if (taken_i) begin
         if (ctr_i != ST) ctr_o = ctr_i + 2'd1;
      end else begin
         if (ctr_i != SNT) ctr_o = ctr_i - 2'd1;
      end
   end

endmodule

// File: rtl/branch_predictor.sv
// Direct-mapped BTB with 2-bit counters; zero-latency lookup, one-edge update.
// Optional saturating statistics counters when BRANCH_PREDICTOR_STATS_EN is defined.
module branch_predictor
   import bp_pkg::*;
#(
   parameter int XLEN    = 32,
   parameter int ENTRIES = 64
) (
   input  logic            clk_i,
   input  logic            rst_i,
   input  logic            flush_i,
   input  logic [XLEN-1:0] pc_i,
   output logic            pred_taken_o,
   output logic [XLEN-1:0] pred_target_o,
   input  logic            upd_valid_i,
   input  logic [XLEN-1:0] upd_pc_i,
   input  logic            upd_taken_i,
   input  logic [XLEN-1:0] upd_target_i,
   input  logic            upd_mispred_i
`ifdef BRANCH_PREDICTOR_STATS_EN
   ,
   output logic [31:0]     lookups_o,
   output logic [31:0]     mispreds_o
`endif
);

   localparam int IDX_W = $clog2(ENTRIES);
   localparam int TAG_W = XLEN - IDX_W - 2;

   bp_entry_t tbl_q [ENTRIES];

   logic [IDX_W-1:0]       rd_idx, wr_idx;
   logic [BP_MAX_XLEN-1:0] rd_tag_x, wr_tag_x, wr_tgt_x;
   logic                   rd_hit, wr_hit, wr_en;
   logic [1:0]             ctr_nxt;
   bp_entry_t              new_ent;

   assign rd_idx = pc_i[IDX_W+1:2];
   assign wr_idx = upd_pc_i[IDX_W+1:2];

   always_comb begin
      rd_tag_x = '0;
      wr_tag_x = '0;
      wr_tgt_x = '0;
      rd_tag_x[TAG_W-1:0] = pc_i[XLEN-1:IDX_W+2];
      wr_tag_x[TAG_W-1:0] = upd_pc_i[XLEN-1:IDX_W+2];
      wr_tgt_x[XLEN-1:0]  = upd_target_i;
   end

   // Lookup reads the registered table only, so same-cycle updates are not visible.
   assign rd_hit = tbl_q[rd_idx].valid && (tbl_q[rd_idx].tag == rd_tag_x);
   assign wr_hit = tbl_q[wr_idx].valid && (tbl_q[wr_idx].tag == wr_tag_x);

   always_comb begin
      pred_taken_o  = 1'b0;
      pred_target_o = pc_i + XLEN'(4);
      if (rd_hit && tbl_q[rd_idx].ctr[1]) begin
         pred_taken_o  = 1'b1;
         pred_target_o = tbl_q[rd_idx].target[XLEN-1:0];
      end
   end

   sat_counter2 u_ctr (
      .ctr_i   (tbl_q[wr_idx].ctr),
      .taken_i (upd_taken_i),
      .ctr_o   (ctr_nxt)
   );

   // Update bundle: upd_* is valid-only, consumed on every edge where upd_valid_i is high;
   // there is no ready, the predictor always accepts. A not-taken miss writes nothing.
   assign wr_en = upd_valid_i && (wr_hit || upd_taken_i);

   always_comb begin
      new_ent = tbl_q[wr_idx];
      if (wr_hit) begin
         new_ent.ctr = ctr_nxt;
         if (upd_taken_i) new_ent.target = wr_tgt_x;
      end else begin
         new_ent.valid  = 1'b1;
         new_ent.ctr    = WT;
         new_ent.tag    = wr_tag_x;
         new_ent.target = wr_tgt_x;
      end
   end

   always_ff @(posedge clk_i or negedge rst_i) begin
      if (!rst_i) begin
         for (int i = 0; i < ENTRIES; i++) begin
            tbl_q[i]     <= '0;
            tbl_q[i].ctr <= WNT;
         end
      end else if (flush_i) begin
         for (int i = 0; i < ENTRIES; i++) tbl_q[i].valid <= 1'b0;
      end else if (wr_en) begin
         tbl_q[wr_idx] <= new_ent;
      end
   end

`ifdef BRANCH_PREDICTOR_STATS_EN
   // Statistics survive a flush; only reset clears them.
   always_ff @(posedge clk_i or negedge rst_i) begin
      if (!rst_i) begin
         lookups_o  <= '0;
         mispreds_o <= '0;
      end else begin
         if (upd_valid_i && (lookups_o != '1)) lookups_o <= lookups_o + 32'd1;
         if (upd_valid_i && upd_mispred_i && (mispreds_o != '1)) mispreds_o <= mispreds_o + 32'd1;
      end
   end

   logic unused_bits;
   assign unused_bits = ^{pc_i[1:0], upd_pc_i[1:0]};
`else
   logic unused_bits;
   assign unused_bits = ^{upd_mispred_i, pc_i[1:0], upd_pc_i[1:0]};
`endif

endmodule

// File: tb/tb_branch_predictor.sv
// Self-checking bench for branch_predictor: vector table, hand-written reset/stats sequences.
module tb_branch_predictor;

   localparam int XLEN = 32;

   logic            clk_i = 1'b0;
   logic            rst_i = 1'b0;
   logic            flush_i = 1'b0;
   logic [XLEN-1:0] pc_i = '0;
   logic            pred_taken_o;
   logic [XLEN-1:0] pred_target_o;
   logic            upd_valid_i = 1'b0;
   logic [XLEN-1:0] upd_pc_i = '0;
   logic            upd_taken_i = 1'b0;
   logic [XLEN-1:0] upd_target_i = '0;
   logic            upd_mispred_i = 1'b0;
`ifdef BRANCH_PREDICTOR_STATS_EN
   logic [31:0]     lookups_o;
   logic [31:0]     mispreds_o;
`endif

   branch_predictor #(.XLEN(XLEN), .ENTRIES(64)) dut (
      .clk_i         (clk_i),
      .rst_i         (rst_i),
      .flush_i       (flush_i),
      .pc_i          (pc_i),
      .pred_taken_o  (pred_taken_o),
      .pred_target_o (pred_target_o),
      .upd_valid_i   (upd_valid_i),
      .upd_pc_i      (upd_pc_i),
      .upd_taken_i   (upd_taken_i),
      .upd_target_i  (upd_target_i),
      .upd_mispred_i (upd_mispred_i)
`ifdef BRANCH_PREDICTOR_STATS_EN
      ,
      .lookups_o     (lookups_o),
      .mispreds_o    (mispreds_o)
`endif
   );

   // ---------------- clock ----------------
   always #5 clk_i = ~clk_i;

   // ---------------- scoreboard ----------------
   logic [XLEN:0] exp_q[$];
   int            n_total = 0;
   int            n_pass  = 0;

   typedef struct {
      logic            flush;
      logic            uv;
      logic [XLEN-1:0] upc;
      logic            ut;
      logic [XLEN-1:0] utgt;
      logic [XLEN-1:0] pc;
      logic            et;
      logic [XLEN-1:0] etgt;
   } vec_t;

   vec_t vecs[$];

   function automatic vec_t mk(input logic fl, input logic uv, input logic [XLEN-1:0] upc,
                               input logic ut, input logic [XLEN-1:0] utgt,
                               input logic [XLEN-1:0] pc, input logic et,
                               input logic [XLEN-1:0] etgt);
      vec_t v;
      v.flush = fl; v.uv = uv; v.upc = upc; v.ut = ut; v.utgt = utgt;
      v.pc = pc; v.et = et; v.etgt = etgt;
      return v;
   endfunction

   task automatic push_exp(input logic t, input logic [XLEN-1:0] tgt);
      exp_q.push_back({t, tgt});
   endtask

   task automatic check_pred(input string name);
      logic [XLEN:0] exp_v;
      n_total++;
      if (exp_q.size() == 0) begin
         $display("FAIL %s: expected queue empty, got taken=%0d target=%h", name, pred_taken_o, pred_target_o);
      end else begin
         exp_v = exp_q.pop_front();
         if ({pred_taken_o, pred_target_o} === exp_v) n_pass++;
         else $display("FAIL %s: got taken=%0d target=%h, expected taken=%0d target=%h",
                       name, pred_taken_o, pred_target_o, exp_v[XLEN], exp_v[XLEN-1:0]);
      end
   endtask

   task automatic check_val(input string name, input logic [31:0] got, input logic [31:0] exp_v);
      n_total++;
      if (got === exp_v) n_pass++;
      else $display("FAIL %s: got %0d, expected %0d", name, got, exp_v);
   endtask

   // ---------------- drivers ----------------
   task automatic drive_vec(input vec_t v, input string name);
      @(negedge clk_i);
      flush_i      = v.flush;
      upd_valid_i  = v.uv;
      upd_pc_i     = v.upc;
      upd_taken_i  = v.ut;
      upd_target_i = v.utgt;
      upd_mispred_i = 1'b0;
      pc_i         = v.pc;
      push_exp(v.et, v.etgt);
      #1 check_pred(name);
   endtask

   task automatic idle_inputs();
      flush_i = 1'b0; upd_valid_i = 1'b0; upd_taken_i = 1'b0; upd_mispred_i = 1'b0;
   endtask

   // ---------------- stimulus ----------------
   initial begin
      logic [XLEN-1:0] rpc;

      // Expected value of each vector is the prediction before that vector's own update.
      vecs.push_back(mk(0, 0, 32'h0,     0, 32'h0,   32'h100, 0, 32'h104));      // cold lookup
      vecs.push_back(mk(0, 1, 32'h100,   1, 32'h200, 32'h100, 0, 32'h104));      // allocate, no bypass
      vecs.push_back(mk(0, 0, 32'h0,     0, 32'h0,   32'h100, 1, 32'h200));      // hit, ctr=WT
      vecs.push_back(mk(0, 1, 32'h100,   1, 32'h200, 32'h100, 1, 32'h200));      // ctr -> ST
      vecs.push_back(mk(0, 1, 32'h100,   1, 32'h200, 32'h100, 1, 32'h200));      // saturate at ST
      vecs.push_back(mk(0, 1, 32'h100,   0, 32'h0,   32'h100, 1, 32'h200));      // ST -> WT
      vecs.push_back(mk(0, 1, 32'h100,   0, 32'h0,   32'h100, 1, 32'h200));      // still taken; WT -> WNT
      vecs.push_back(mk(0, 1, 32'h100,   0, 32'h0,   32'h100, 0, 32'h104));      // not taken; WNT -> SNT
      vecs.push_back(mk(0, 1, 32'h100,   1, 32'h280, 32'h100, 0, 32'h104));      // SNT -> WNT, new target
      vecs.push_back(mk(0, 1, 32'h100,   1, 32'h280, 32'h100, 0, 32'h104));      // WNT -> WT
      vecs.push_back(mk(0, 1, 32'h200,   1, 32'h300, 32'h100, 1, 32'h280));      // alias evicts 0x100
      vecs.push_back(mk(0, 0, 32'h0,     0, 32'h0,   32'h100, 0, 32'h104));      // evicted
      vecs.push_back(mk(0, 1, 32'h340,   0, 32'h0,   32'h200, 1, 32'h300));      // NT miss: no write
      vecs.push_back(mk(0, 1, 32'h100,   1, 32'h600, 32'h340, 0, 32'h344));      // re-evict 0x200
      vecs.push_back(mk(0, 1, 32'h200,   0, 32'h0,   32'h100, 1, 32'h600));      // NT miss on 0x200
      vecs.push_back(mk(1, 1, 32'h140,   1, 32'h700, 32'h100, 1, 32'h600));      // flush beats update
      vecs.push_back(mk(0, 0, 32'h0,     0, 32'h0,   32'h100, 0, 32'h104));
      vecs.push_back(mk(0, 0, 32'h0,     0, 32'h0,   32'h140, 0, 32'h144));
      vecs.push_back(mk(0, 1, 32'hFFFFFFFC, 1, 32'h10, 32'hFFFFFFFC, 0, 32'h0)); // pc+4 wraps
      vecs.push_back(mk(0, 0, 32'h0,     0, 32'h0,   32'hFFFFFFFE, 1, 32'h10));  // pc[1:0] ignored
      vecs.push_back(mk(0, 0, 32'h100,   1, 32'h800, 32'h100, 0, 32'h104));      // upd_valid=0 ignored
      vecs.push_back(mk(0, 0, 32'h0,     0, 32'h0,   32'h100, 0, 32'h104));

      // Reset held: outputs must show a miss.
      pc_i = 32'h100;
      push_exp(1'b0, 32'h104);
      #1 check_pred("in_reset");
      repeat (2) @(negedge clk_i);
      rst_i = 1'b1;

      foreach (vecs[i]) drive_vec(vecs[i], $sformatf("vec%0d", i));

      // Reset mid-update clears live entries and drops the pending update.
      drive_vec(mk(0, 1, 32'h140, 1, 32'h700, 32'h140, 0, 32'h144), "alloc_140");
      drive_vec(mk(0, 0, 32'h0,   0, 32'h0,   32'h140, 1, 32'h700), "hit_140");
      @(negedge clk_i);
      upd_valid_i = 1'b1; upd_pc_i = 32'h100; upd_taken_i = 1'b1; upd_target_i = 32'h900;
      pc_i = 32'h140;
      rst_i = 1'b0;
      push_exp(1'b0, 32'h144);
      #1 check_pred("rst_async_clear");
      @(negedge clk_i);
      idle_inputs();
      rst_i = 1'b1;
      pc_i = 32'h100;
      push_exp(1'b0, 32'h104);
      #1 check_pred("rst_drops_update");
      pc_i = 32'hFFFFFFFE;
      push_exp(1'b0, 32'h2);
      #1 check_pred("rst_clears_top_entry");

      // Random cold lookups: an empty table always predicts fall-through.
      for (int i = 0; i < 8; i++) begin
         @(negedge clk_i);
         rpc = XLEN'($urandom_range(0, 32'h3FFF_FFFF)) << 2;
         rpc[1:0] = 2'($urandom_range(0, 3));
         pc_i = rpc;
         push_exp(1'b0, rpc + 32'd4);
         #1 check_pred($sformatf("cold_rand%0d", i));
      end

`ifdef BRANCH_PREDICTOR_STATS_EN
      @(negedge clk_i);
      rst_i = 1'b0;
      @(negedge clk_i);
      rst_i = 1'b1;
      for (int i = 0; i < 5; i++) begin
         @(negedge clk_i);
         upd_valid_i = 1'b1; upd_pc_i = 32'h100 + 32'(i * 4); upd_taken_i = 1'b1;
         upd_target_i = 32'h400; upd_mispred_i = (i == 1) || (i == 3);
      end
      @(negedge clk_i);
      idle_inputs();
      #1;
      check_val("stats_lookups", lookups_o, 32'd5);
      check_val("stats_mispreds", mispreds_o, 32'd2);
      rst_i = 1'b0;
      #1;
      check_val("stats_lookups_rst", lookups_o, 32'd0);
      check_val("stats_mispreds_rst", mispreds_o, 32'd0);
      @(negedge clk_i);
      rst_i = 1'b1;
`endif

      if (exp_q.size() != 0) begin
         n_total++;
         $display("FAIL leftover_expected: got %0d queued, expected 0", exp_q.size());
      end

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule

// File: doc/branch_predictor.md
BRANCH_PREDICTOR -- requirements
Module: branch_predictor

Interface
REQ-001 Parameter XLEN, default 32, SHALL set the PC and target width.
REQ-002 Parameter ENTRIES, default 64, SHALL set the table depth; it SHALL be a power of two and at least 4.
REQ-003 Derived IDX_W = log2(ENTRIES) and TAG_W = XLEN-IDX_W-2 SHALL be localparams, not overridable.
REQ-004 clk_i  input  1  the single clock; all state SHALL update on the rising edge.
REQ-005 rst_i  input  1  reset, asynchronous and active-low.
REQ-006 flush_i  input  1  high for one cycle invalidates every entry.
REQ-007 pc_i  input  XLEN  fetch PC to predict.
REQ-008 pred_taken_o  output  1  prediction for pc_i.
REQ-009 pred_target_o  output  XLEN  next fetch PC for pc_i.
REQ-010 upd_valid_i  input  1  qualifies the resolved-branch update bundle.
REQ-011 upd_pc_i  input  XLEN  PC of the resolved branch.
REQ-012 upd_taken_i  input  1  actual outcome of the resolved branch.
REQ-013 upd_target_i  input  XLEN  actual target of the resolved branch.
REQ-014 upd_mispred_i  input  1  the EX stage flagged a misprediction.

Function
REQ-015 Index SHALL be pc[IDX_W+1:2] and tag SHALL be pc[XLEN-1:IDX_W+2]; pc[1:0] SHALL be ignored.
REQ-016 Each entry SHALL hold: valid (1 bit), tag (TAG_W bits), target (XLEN bits) and a 2-bit saturating counter.
REQ-017 Lookup SHALL be combinational from the registered table, with zero-cycle latency.
REQ-018 Hit (valid and tag equal) with counter[1]=1 SHALL give pred_taken_o=1 and pred_target_o=the stored target.
REQ-019 Miss, or hit with counter[1]=0, SHALL give pred_taken_o=0 and pred_target_o=pc_i+4, wrapping modulo 2^XLEN.
REQ-020 Update on hit SHALL do the following at the next edge:
- counter +1 if taken, saturating at 11; counter -1 if not taken, saturating at 00;
- target overwritten with upd_target_i when taken.
REQ-021 Update on miss with upd_taken_i=1 SHALL allocate the entry: valid=1, new tag, target=upd_target_i, counter=10. Any prior occupant SHALL be replaced.
REQ-022 Update on miss with upd_taken_i=0 SHALL leave the table unchanged.
REQ-023 Lookup and update to the same index in the same cycle SHALL return the pre-update contents; there is no bypass.
REQ-024 If flush_i and upd_valid_i are both high, flush SHALL win: all entries invalid and the update dropped.
REQ-025 Inputs with upd_valid_i=0 SHALL be ignored.

Reset
REQ-026 While rst_i=0, all valid bits and counters SHALL clear (counter=01, weakly not-taken) asynchronously. Tags and targets need no reset.
REQ-027 During reset, outputs SHALL read pred_taken_o=0 and pred_target_o=pc_i+4. Reset mid-update SHALL discard the update.

Configuration
REQ-028 Macro BRANCH_PREDICTOR_STATS_EN, when defined, SHALL add:
- output lookups_o, 32 bits: counts cycles with upd_valid_i=1;
- output mispreds_o, 32 bits: counts cycles with upd_valid_i and upd_mispred_i both high.
Both counters SHALL saturate at 0xFFFFFFFF and clear on reset, but not on flush.
REQ-029 Without BRANCH_PREDICTOR_STATS_EN, those ports and counters SHALL be absent and upd_mispred_i SHALL be unused.

Structure
REQ-030 A shared package bp_pkg SHALL hold the 2-bit counter encoding constants (SNT=00, WNT=01, WT=10, ST=11) and the entry struct typedef.
REQ-031 Saturating-counter next-state logic SHALL be a sub-module sat_counter2, instantiated once on the update path.

Verification
REQ-032 Cold lookup: reset, then pc_i=0x100 -> pred_taken_o=0 and pred_target_o=0x104.
REQ-033 Allocate then hit: update pc=0x100, taken, target=0x200; next cycle pc_i=0x100 -> pred_taken_o=1 and pred_target_o=0x200.
REQ-034 Saturation and hysteresis: three taken updates on 0x100 give counter=11. Then:
- one not-taken update -> still predicts taken;
- a second not-taken update -> predicts not-taken, target 0x104.
REQ-035 Alias eviction: allocate 0x100; then allocate 0x200 as taken with target 0x300 (same index 0, ENTRIES=64). Then:
- pc_i=0x100 -> miss, target 0x104;
- pc_i=0x200 -> target 0x300.
REQ-036 Flush versus update collision: flush_i=1 in the same cycle as a taken update on 0x140 -> pc_i=0x100 and 0x140 both miss the next cycle.
REQ-037 Stats, with BRANCH_PREDICTOR_STATS_EN defined: 5 updates with 2 mispredictions flagged -> lookups_o=5 and mispreds_o=2. Asserting rst_i=0 mid-run -> both read 0 immediately.
